// File: rtl/mem_arbiter_if.sv
// Bus bundle between N valid/ready memory masters, the arbiter and one memory slave.
// "slave" is the arbiter's view; "master" is the environment driving requests and the memory.
interface mem_arbiter_if #(
  parameter int N_MASTERS = 2
);
  logic [N_MASTERS-1:0]    m_valid;
  logic [N_MASTERS-1:0]    m_ready;
  logic [N_MASTERS*32-1:0] m_addr;
  logic [N_MASTERS*32-1:0] m_wdata;
  logic [N_MASTERS*4-1:0]  m_wstrb;
  logic [N_MASTERS-1:0]    m_lock;
  logic [31:0]             m_rdata;
  logic                    s_valid;
  logic                    s_ready;
  logic [31:0]             s_addr;
  logic [31:0]             s_wdata;
  logic [3:0]              s_wstrb;
  logic [31:0]             s_rdata;

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb, m_lock, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb, m_lock, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory slave among N_MASTERS masters,
// with a per-master lock that keeps the grant across back-to-back transactions.
module mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int GW        = (N_MASTERS > 2) ? $clog2(N_MASTERS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic [GW-1:0] grant,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [GW-1:0] last;
  logic          win_found;
  logic [GW-1:0] win_idx;

  // Round-robin pick: first requester scanning upward from last+1, wrapping modulo N.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      int j;
      j = (int'(last) + 1 + i) % N_MASTERS;
      if (!win_found && bus.m_valid[j]) begin
        win_found = 1'b1;
        win_idx   = GW'(j);
      end else begin
        win_found = win_found;
      end
    end
  end

  // Arbitration state machine; grant, last and busy only move on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(N_MASTERS - 1);
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= win_idx;
            last  <= win_idx;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (bus.s_ready) begin
            if (bus.m_lock[grant]) begin
              state <= LOCKED;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else if (!bus.m_valid[grant]) begin
            // Owner withdrew its request before the slave answered.
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        LOCKED: begin
          if (bus.m_valid[grant]) begin
            state <= BUSY;
          end else if (!bus.m_lock[grant]) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Route the owner onto the slave and its ack back; bus is parked at zero outside BUSY.
  always_comb begin
    bus.m_ready = '0;
    bus.s_valid = 1'b0;
    bus.s_addr  = 32'd0;
    bus.s_wdata = 32'd0;
    bus.s_wstrb = 4'd0;
    if (state == BUSY) begin
      bus.s_valid        = bus.m_valid[grant];
      bus.s_addr         = bus.m_addr[int'(grant)*32 +: 32];
      bus.s_wdata        = bus.m_wdata[int'(grant)*32 +: 32];
      bus.s_wstrb        = bus.m_wstrb[int'(grant)*4 +: 4];
      bus.m_ready[grant] = bus.s_ready;
    end else begin
      bus.m_ready = '0;
    end
  end

  assign bus.m_rdata = bus.s_rdata;

endmodule
